// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS instruction fetch initiator with PC, wait timer and decode handshake
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   stall            decode not ready; holds the presented instruction
//   redirect         branch/jump taken (single-cycle pulse), highest priority
//   redirect_pc      target byte address; low 2 bits are ignored
//   imem_addr        registered byte address to instruction memory (== pc)
//   imem_rdata       instruction word returned by instruction memory
//   if_instr         fetched instruction
//   if_pc            byte address of if_instr
//   if_pc_plus4      if_pc + 4, modulo 2^32
//   if_valid         if_instr/if_pc valid for decode
//   fetch_count      number of instructions accepted by decode
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic [31:0] fetch_count
);

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] PC_INIT   = RESET_PC & ~32'h3;

  typedef enum logic {ST_WAIT, ST_VALID} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        accept;

  // Decode takes the presented instruction whenever it is valid and not stalled,
  // even in the same cycle as a redirect.
  assign accept = (state_q == ST_VALID) && !stall;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      // Any in-flight fetch is dropped: no capture happens on this edge.
      pc_d       = redirect_pc & ~32'h3;
      if_valid_d = 1'b0;
      wait_cnt_d = WAIT_INIT;
      state_d    = ST_WAIT;
      if (accept) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (wait_cnt_q != 4'd0) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end else begin
            // Memory output has settled for the current address.
            if_instr_d    = imem_rdata;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_q + 32'd4;
            if_valid_d    = 1'b1;
            state_d       = ST_VALID;
          end
        end
        ST_VALID: begin
          if (!stall) begin
            fetch_count_d = fetch_count_q + 32'd1;
            pc_d          = pc_q + 32'd4;
            if_valid_d    = 1'b0;
            wait_cnt_d    = WAIT_INIT;
            state_d       = ST_WAIT;
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT;
      wait_cnt_q    <= WAIT_INIT;
      pc_q          <= PC_INIT;
      if_instr_q    <= 32'h0;
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'd4;
      if_valid_q    <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign if_valid    = if_valid_q;
  assign fetch_count = fetch_count_q;

endmodule
